// File: rtl/cv32e40p_x_disp_mo.sv
// cv32e40p_x_disp_mo: multi-outstanding X-interface dispatcher with an ID-tagged in-flight table
//   Ports: issue handshake (x_valid_o/x_ready_i/x_accept_i), result channel (x_rvalid_i/x_rid_i),
//   register-file write steering, dependency/stall generation, coprocessor memory request gating.
//   Optional macro CV32E40P_X_DISP_PERF_EN adds perf_offload_cnt_o and perf_memstall_cnt_o.
module cv32e40p_x_disp_mo #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4,
    parameter int NUM_RS   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   x_illegal_insn_dec_i,
    input  logic                   x_branch_or_jump_i,
    input  logic                   x_data_req_dec_i,
    input  logic                   id_ready_i,
    input  logic [4:0]             x_waddr_id_i,
    input  logic                   x_writeback_i,
    input  logic [4:0]             x_waddr_ex_i,
    input  logic [4:0]             x_waddr_wb_i,
    input  logic                   x_we_ex_i,
    input  logic                   x_we_wb_i,
    input  logic [NUM_RS-1:0][4:0] x_rs_addr_i,
    input  logic [NUM_RS-1:0]      x_regs_used_i,
    output logic                   x_valid_o,
    input  logic                   x_ready_i,
    input  logic                   x_accept_i,
    input  logic                   x_is_mem_op_i,
    output logic [ID_WIDTH-1:0]    x_id_o,
    output logic [NUM_RS-1:0]      x_rs_valid_o,
    output logic                   x_rd_clean_o,
    output logic                   x_stall_o,
    output logic                   x_illegal_insn_o,
    input  logic                   x_rvalid_i,
    output logic                   x_rready_o,
    input  logic [ID_WIDTH-1:0]    x_rid_i,
    output logic                   x_rf_we_o,
    output logic [4:0]             x_rf_waddr_o,
    output logic                   x_id_err_o,
    input  logic                   xmem_valid_i,
    output logic                   xmem_ready_o,
    input  logic                   xmem_we_i,
    input  logic                   xmem_last_i,
    output logic                   xmem_data_req_o,
    output logic                   xmem_we_o
`ifdef CV32E40P_X_DISP_PERF_EN
    ,
    output logic [31:0]            perf_offload_cnt_o,
    output logic [31:0]            perf_memstall_cnt_o
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0]      vld_q, wb_q;
    logic [DEPTH-1:0][4:0] rd_q;
    logic                  offl_q, err_q;
    logic [CW-1:0]         mem_cnt_q;
    logic [ID_WIDTH-1:0]   free_id;
    logic [31:0]           pend;
    logic                  full, hs, acc, hit, hit_wb, rd_busy, dep, mem_stall, inc, dec;
    logic [4:0]            hit_rd;
    // Table lookups: lowest free slot, result hit, and the pending-writer map from registered state.
    // rd_busy ignores the entry being freed by this cycle's result.
    always_comb begin
        free_id = '0;
        hit     = 1'b0;
        hit_wb  = 1'b0;
        hit_rd  = '0;
        pend    = '0;
        rd_busy = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!vld_q[i]) free_id = ID_WIDTH'(i);
        for (int i = 0; i < DEPTH; i++) begin
            if (x_rid_i == ID_WIDTH'(i)) begin
                hit    = x_rvalid_i & vld_q[i];
                hit_wb = wb_q[i];
                hit_rd = rd_q[i];
            end
            if (vld_q[i] && wb_q[i]) pend[rd_q[i]] = 1'b1;
            if (vld_q[i] && wb_q[i] && rd_q[i] == x_waddr_id_i && !(hit && x_rid_i == ID_WIDTH'(i)))
                rd_busy = 1'b1;
        end
    end
    assign full             = &vld_q;
    assign x_id_o           = free_id;
    assign x_valid_o        = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offl_q & ~full;
    assign hs               = x_valid_o & x_ready_i;
    assign acc              = hs & x_accept_i;
    assign x_illegal_insn_o = hs & ~x_accept_i;
    assign x_rready_o       = 1'b1;
    assign x_rf_we_o        = hit & hit_wb;
    assign x_rf_waddr_o     = hit_rd;
    assign x_id_err_o       = err_q;
    assign x_rd_clean_o     = ~(rd_busy | (x_waddr_id_i == x_waddr_ex_i & x_we_ex_i) |
                                (x_waddr_id_i == x_waddr_wb_i & x_we_wb_i));
    always_comb begin
        dep = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            x_rs_valid_o[i] = ~(pend[x_rs_addr_i[i]] | (x_rs_addr_i[i] == x_waddr_ex_i & x_we_ex_i) |
                                (x_rs_addr_i[i] == x_waddr_wb_i & x_we_wb_i));
            dep = dep | (x_regs_used_i[i] & pend[x_rs_addr_i[i]]);
        end
        dep = dep & ~x_illegal_insn_o;
    end
    assign inc             = acc & x_is_mem_op_i;
    assign dec             = xmem_valid_i & xmem_last_i;
    assign mem_stall       = x_data_req_dec_i & (mem_cnt_q != '0);
    assign xmem_ready_o    = xmem_valid_i;
    assign xmem_data_req_o = xmem_valid_i;
    assign xmem_we_o       = xmem_valid_i & xmem_we_i;
    assign x_stall_o       = (x_valid_o & ~x_ready_i) | dep | mem_stall |
                             (x_illegal_insn_dec_i & (x_branch_or_jump_i | (full & ~offl_q))) |
                             (xmem_valid_i & ~hs);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            wb_q      <= '0;
            rd_q      <= '0;
            offl_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit && x_rid_i == ID_WIDTH'(i)) vld_q[i] <= 1'b0;
                if (acc && free_id == ID_WIDTH'(i)) begin
                    vld_q[i] <= 1'b1;
                    rd_q[i]  <= x_waddr_id_i;
                    wb_q[i]  <= x_writeback_i & (x_waddr_id_i != 5'd0);
                end
            end
            offl_q <= id_ready_i ? 1'b0 : (hs ? 1'b1 : offl_q);
            err_q  <= err_q | (x_rvalid_i & ~hit);
            // Simultaneous increment and decrement cancel; decrement never wraps below zero.
            mem_cnt_q <= (inc & ~dec) ? mem_cnt_q + CW'(1) :
                         (dec & ~inc & mem_cnt_q != '0) ? mem_cnt_q - CW'(1) : mem_cnt_q;
        end
    end
`ifdef CV32E40P_X_DISP_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_offload_cnt_o  <= '0;
            perf_memstall_cnt_o <= '0;
        end else begin
            perf_offload_cnt_o  <= perf_offload_cnt_o + {31'd0, acc};
            perf_memstall_cnt_o <= perf_memstall_cnt_o + {31'd0, mem_stall};
        end
    end
`endif
endmodule

// File: tb/tb_cv32e40p_x_disp_mo.sv
// tb_cv32e40p_x_disp_mo: directed self-checking bench for cv32e40p_x_disp_mo
module tb_cv32e40p_x_disp_mo;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic illegal = 0, bj = 0, data_req = 0, id_ready = 1, writeback = 0;
    logic [4:0] waddr_id = 0, waddr_ex = 0, waddr_wb = 0;
    logic we_ex = 0, we_wb = 0;
    logic [2:0][4:0] rs_addr = '0;
    logic [2:0] regs_used = 0;
    logic ready = 0, accept = 0, is_mem = 0, rvalid = 0;
    logic [3:0] rid = 0;
    logic xmv = 0, xmwe = 0, xmlast = 0;
    logic x_valid, rd_clean, stall, ill_o, rready, rf_we, id_err, xm_ready, xm_req, xm_we;
    logic [3:0] x_id;
    logic [2:0] rs_valid;
    logic [4:0] rf_waddr;
`ifdef CV32E40P_X_DISP_PERF_EN
    logic [31:0] perf_off, perf_ms;
`endif
    int total = 0, bad = 0;

    cv32e40p_x_disp_mo dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_illegal_insn_dec_i(illegal), .x_branch_or_jump_i(bj), .x_data_req_dec_i(data_req),
        .id_ready_i(id_ready), .x_waddr_id_i(waddr_id), .x_writeback_i(writeback),
        .x_waddr_ex_i(waddr_ex), .x_waddr_wb_i(waddr_wb), .x_we_ex_i(we_ex), .x_we_wb_i(we_wb),
        .x_rs_addr_i(rs_addr), .x_regs_used_i(regs_used),
        .x_valid_o(x_valid), .x_ready_i(ready), .x_accept_i(accept), .x_is_mem_op_i(is_mem),
        .x_id_o(x_id), .x_rs_valid_o(rs_valid), .x_rd_clean_o(rd_clean), .x_stall_o(stall),
        .x_illegal_insn_o(ill_o), .x_rvalid_i(rvalid), .x_rready_o(rready), .x_rid_i(rid),
        .x_rf_we_o(rf_we), .x_rf_waddr_o(rf_waddr), .x_id_err_o(id_err),
        .xmem_valid_i(xmv), .xmem_ready_o(xm_ready), .xmem_we_i(xmwe), .xmem_last_i(xmlast),
        .xmem_data_req_o(xm_req), .xmem_we_o(xm_we)
`ifdef CV32E40P_X_DISP_PERF_EN
        , .perf_offload_cnt_o(perf_off), .perf_memstall_cnt_o(perf_ms)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        tick; tick;
        rst_i = 0;
        settle;
        chk("rst_valid", x_valid, 0);
        chk("rst_rready", rready, 1);
        chk("rst_id", x_id, 0);
        chk("rst_err", id_err, 0);
        chk("rst_stall", stall, 0);
        // fill all four entries with rd 5..8
        illegal = 1; ready = 1; accept = 1; writeback = 1;
        for (int k = 0; k < 4; k++) begin
            waddr_id = 5'(5 + k);
            settle;
            chk("fill_valid", x_valid, 1);
            chk("fill_id", x_id, k);
            tick;
        end
        settle;
        chk("full_valid", x_valid, 0);
        chk("full_stall", stall, 1);
        waddr_id = 7; ready = 0; accept = 0;
        settle;
        chk("rd7_busy", rd_clean, 0);
        rvalid = 1; rid = 2;
        settle;
        chk("ooo_we", rf_we, 1);
        chk("ooo_waddr", rf_waddr, 7);
        chk("ooo_rdclean", rd_clean, 1);
        tick;
        rvalid = 0;
        settle;
        chk("refill_id", x_id, 2);
        chk("refill_valid", x_valid, 1);
        // dependency on rd 8 held by ID 3
        illegal = 0;
        rs_addr[0] = 8; regs_used = 3'b001; waddr_id = 8;
        settle;
        chk("dep_stall", stall, 1);
        chk("dep_rsvalid", rs_valid, 3'b110);
        rvalid = 1; rid = 3;
        settle;
        chk("dep_rdclean", rd_clean, 1);
        chk("dep_stall_same", stall, 1);
        tick;
        rvalid = 0;
        settle;
        chk("dep_released", stall, 0);
        chk("dep_rsvalid2", rs_valid, 3'b111);
        rs_addr[1] = 12; waddr_ex = 12; we_ex = 1;
        settle;
        chk("ex_hazard", rs_valid, 3'b101);
        we_ex = 0; rs_addr[1] = 0;
        // rejection masks the dependency on rd 5
        rs_addr[0] = 5; illegal = 1; ready = 1; accept = 0;
        settle;
        chk("rej_ill", ill_o, 1);
        chk("rej_stall_masked", stall, 0);
        chk("rej_rsvalid", rs_valid, 3'b110);
        tick;
        illegal = 0;
        settle;
        chk("rej_ill_drop", ill_o, 0);
        chk("rej_noalloc", x_id, 2);
        chk("rej_dep_stall", stall, 1);
        // offload with id_ready low blocks the next offer; rd 0 is never pending
        regs_used = 0; illegal = 1; accept = 1; id_ready = 0; waddr_id = 0; writeback = 1;
        tick;
        settle;
        chk("offl_valid", x_valid, 0);
        chk("offl_stall", stall, 0);
        id_ready = 1; ready = 0; accept = 0;
        tick;
        settle;
        chk("offl_clear", x_valid, 1);
        chk("offl_id", x_id, 3);
        illegal = 0;
        rvalid = 1;
        rid = 0; settle; chk("ret0_we", rf_we, 1); chk("ret0_waddr", rf_waddr, 5); tick;
        rid = 1; settle; chk("ret1_waddr", rf_waddr, 6); tick;
        rid = 2; settle; chk("ret2_rd0_we", rf_we, 0); tick;
        rvalid = 0;
        // memory gating
        illegal = 1; ready = 1; accept = 1; is_mem = 1; writeback = 0; waddr_id = 10;
        tick; tick;
        illegal = 0; ready = 0; accept = 0; is_mem = 0; data_req = 1;
        settle;
        chk("mem2_stall", stall, 1);
        data_req = 0; illegal = 1; ready = 1; accept = 1; is_mem = 1;
        xmv = 1; xmlast = 1; xmwe = 1;
        settle;
        chk("xm_ready", xm_ready, 1);
        chk("xm_req", xm_req, 1);
        chk("xm_we", xm_we, 1);
        chk("xm_hs_nostall", stall, 0);
        tick;
        illegal = 0; ready = 0; accept = 0; is_mem = 0; xmv = 0; data_req = 1;
        settle;
        chk("mem_hold_stall", stall, 1);
        data_req = 0; xmv = 1; xmwe = 0;
        settle;
        chk("xm_we_rd", xm_we, 0);
        chk("xm_stall", stall, 1);
        tick; tick;
        xmv = 0; data_req = 1;
        settle;
        chk("mem0_nostall", stall, 0);
        data_req = 0; xmv = 1;
        tick;
        xmv = 0; data_req = 1;
        settle;
        chk("mem_underflow", stall, 0);
        data_req = 0;
        // unknown ID
        rvalid = 1; rid = 3;
        settle;
        chk("unk_we", rf_we, 0);
        tick;
        rvalid = 0;
        settle;
        chk("unk_err", id_err, 1);
        illegal = 1; ready = 1; accept = 1; is_mem = 1; writeback = 1; waddr_id = 9;
        tick;
        illegal = 0; ready = 0; accept = 0; is_mem = 0;
        rs_addr[0] = 9; regs_used = 3'b001;
        settle;
        chk("pre_rst_stall", stall, 1);
        chk("err_sticky", id_err, 1);
        // reset mid-operation
        rst_i = 1;
        tick;
        rst_i = 0; data_req = 1;
        settle;
        chk("mid_rst_id", x_id, 0);
        chk("mid_rst_rsvalid", rs_valid, 3'b111);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_err", id_err, 0);
        chk("mid_rst_valid", x_valid, 0);
`ifdef CV32E40P_X_DISP_PERF_EN
        chk("perf_off_rst", perf_off, 0);
        chk("perf_ms_rst", perf_ms, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cv32e40p_x_disp_mo.md
# cv32e40p_x_disp_mo

Multi-outstanding X-interface dispatcher for the cv32e40p ID stage. It offloads decoded-illegal instructions to an external coprocessor and tracks up to `DEPTH` in-flight offloads in an ID-tagged table, so results may return out of order. It derives register-dependency stalls from that table, steers returning results into the integer register file, and gates core loads/stores against outstanding coprocessor memory operations.

## Interface
Parameters:
- `DEPTH`, 4: in-flight table entries; legal range 1..16.
- `ID_WIDTH`, 4: width of the offload ID; must satisfy 2^`ID_WIDTH` >= `DEPTH`.
- `NUM_RS`, 3: source operands per instruction; legal values 2 or 3.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `x_illegal_insn_dec_i` in 1: the decoder flagged the ID instruction as not core-native.
- `x_branch_or_jump_i` in 1: a branch or jump is unresolved.
- `x_data_req_dec_i` in 1: the ID instruction is a core load/store.
- `id_ready_i` in 1: the ID stage advances this cycle.
- `x_waddr_id_i` in 5: rd of the ID instruction.
- `x_writeback_i` in 1: the ID instruction writes rd.
- `x_waddr_ex_i`, `x_waddr_wb_i` in 5 each: rd in EX and WB.
- `x_we_ex_i`, `x_we_wb_i` in 1 each: write enables for EX and WB.
- `x_rs_addr_i` in `NUM_RS`x5: source register addresses.
- `x_regs_used_i` in `NUM_RS`: which sources are read.
- `x_valid_o` out 1, `x_ready_i` in 1, `x_accept_i` in 1, `x_is_mem_op_i` in 1: issue handshake.
- `x_id_o` out `ID_WIDTH`: ID of the offered instruction.
- `x_rs_valid_o` out `NUM_RS`: source operands are clean.
- `x_rd_clean_o` out 1: rd has no pending writer.
- `x_stall_o` out 1: stall request to ID.
- `x_illegal_insn_o` out 1: the coprocessor rejected the instruction.
- `x_rvalid_i` in 1, `x_rready_o` out 1, `x_rid_i` in `ID_WIDTH`: result channel.
- `x_rf_we_o` out 1, `x_rf_waddr_o` out 5: register-file write steering for the result.
- `x_id_err_o` out 1: sticky flag, set when a result arrives with an unknown ID.
- `xmem_valid_i` in 1, `xmem_ready_o` out 1, `xmem_we_i` in 1, `xmem_last_i` in 1: coprocessor memory request.
- `xmem_data_req_o` out 1, `xmem_we_o` out 1: LSU request.

## Operation
- Table entry fields: `vld`, `rd[4:0]`, `wb`, `mem`. `x_id_o` is the index of the lowest-numbered free entry. `full` means all entries have `vld` set.
- `x_valid_o = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offl_q & ~full`.
- Accept (`x_valid_o & x_ready_i & x_accept_i`): the entry at `x_id_o` gets `vld=1`, `rd=x_waddr_id_i`, `wb=x_writeback_i & (rd!=0)`, `mem=x_is_mem_op_i`.
- Reject (`x_valid_o & x_ready_i & ~x_accept_i`): `x_illegal_insn_o=1` for that cycle; no allocation.
- `offl_q`: cleared when `id_ready_i` is high; otherwise set on any handshake. Clear has priority.
- Results: `x_rready_o=1` at all times.
  - If `x_rvalid_i` and entry `x_rid_i` has `vld` set: the entry is freed, `x_rf_we_o=wb`, `x_rf_waddr_o=rd`.
  - If the entry has `vld` clear: `x_rf_we_o=0` and `x_id_err_o` is set; it clears only on reset.
- `pend[r]` = OR over entries with `vld & wb & rd==r`, computed from registered state only.
- `x_rs_valid_o[i] = ~(pend[rs_i] | (rs_i==waddr_ex & we_ex) | (rs_i==waddr_wb & we_wb))`.
- `x_rd_clean_o`: same form using rd, except an entry freed by this cycle's result does not count as pending.
- `dep = ~x_illegal_insn_o & OR_i(x_regs_used_i[i] & pend[rs_i])`.
- `mem_cnt`: width `$clog2(DEPTH+1)`.
  - +1 on an accepted mem offload; -1 on `xmem_valid_i & xmem_last_i`.
  - Both in the same cycle: hold. A decrement at 0 is ignored.
- `mem_stall = x_data_req_dec_i & (mem_cnt!=0)`.
- `xmem_ready_o = xmem_data_req_o = xmem_valid_i`; `xmem_we_o = xmem_valid_i & xmem_we_i`.
- `x_stall_o = (x_valid_o & ~x_ready_i) | dep | mem_stall | (x_illegal_insn_dec_i & (x_branch_or_jump_i | (full & ~offl_q))) | (xmem_valid_i & ~(x_valid_o & x_ready_i))`.

## Timing
- Reset clears every `vld`, `offl_q`, `mem_cnt` and `x_id_err_o`. Out of reset, `x_valid_o=0` unless an illegal instruction is decoded; `x_rready_o=1`.
- The remaining outputs are combinational in the inputs and registered state.
- An allocation affects `pend`, `full` and `x_id_o` from the next cycle.
- A free affects `x_rd_clean_o` in the same cycle and everything else from the next cycle.
- Allocate and free of the same index in one cycle cannot occur, because only free entries are allocated.
- A free while `full`: `x_valid_o` rises the next cycle.
- A result with a `vld` ID arriving in the cycle a new entry is allocated: both take effect.

## Configuration
- `CV32E40P_X_DISP_PERF_EN` defined: adds ports `perf_offload_cnt_o` out 32 and `perf_memstall_cnt_o` out 32.
  - `perf_offload_cnt_o` counts accepts; `perf_memstall_cnt_o` counts cycles with `mem_stall`.
  - Both are wrapping counters, reset to 0.
- Macro undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Out-of-order results: `DEPTH=4`; accept 4 offloads (rd 5,6,7,8, `wb=1`). Then `x_valid_o=0` and `x_stall_o=1`. Return ID 2 -> `x_rf_waddr_o=7`, `x_rf_we_o=1`; the next cycle `x_id_o=2` and `x_valid_o=1`.
- Rejection: `x_accept_i=0` -> `x_illegal_insn_o=1` for one cycle; no entry allocated; `dep` masked.
- Dependency: pending rd=9, decoded rs1=9 with `regs_used[0]=1` -> `x_stall_o=1`. On the same-cycle result for that ID -> `x_rd_clean_o=1`; the stall drops the next cycle.
- Memory gating: 2 accepted mem offloads -> `mem_cnt=2`; a core `lw` stalls. One `xmem_last_i` together with a new mem accept -> `mem_cnt` stays 2. Two more `xmem_last_i` -> 0; the stall clears.
- Unknown ID: `x_rvalid_i` with a free ID 3 -> `x_rf_we_o=0`; `x_id_err_o=1` until `rst_i`.
- Reset mid-operation: 3 entries valid; `rst_i` pulsed -> next cycle `x_id_o=0`, all `x_rs_valid_o=1`, `mem_cnt=0`, perf counters 0.
